// File: rtl/lp_decimator.sv
// Keep-every-D-th-sample decimator on a ready/valid stream.
// One output register, a phase counter and a wrapping count of emitted samples.
module lp_decimator #(
  parameter int W = 32,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] x_data,
  input  logic         x_valid,
  output logic         x_ready,
  output logic [W-1:0] y_data,
  output logic         y_valid,
  input  logic         y_ready,
  input  logic         phase_sync,
  output logic [15:0]  keep_count
);

  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(D - 1);

  logic [PW-1:0] ph;
  logic          on_keep_phase;
  logic          hs_in;
  logic          hs_out;
  logic          keep;

  assign on_keep_phase = (ph == '0);
  // Drop-phase samples never stall; only a keep-phase sample waits on the output register.
  assign x_ready = ~on_keep_phase | ~y_valid | y_ready;
  assign hs_in   = x_valid & x_ready;
  assign hs_out  = y_valid & y_ready;
  assign keep    = hs_in & on_keep_phase;

  // Sample arriving with phase_sync is classified on the old phase; sync wins the update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= '0;
    end else if (phase_sync) begin
      ph <= '0;
    end else if (hs_in) begin
      ph <= (ph == PH_LAST) ? '0 : ph + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_data  <= '0;
      y_valid <= 1'b0;
    end else if (keep) begin
      y_data  <= x_data;
      y_valid <= 1'b1;
    end else if (hs_out) begin
      y_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keep_count <= '0;
    end else if (hs_out) begin
      keep_count <= keep_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_lp_decimator.sv
// Self-checking bench for lp_decimator: a D=4 instance and a D=1 instance,
// each compared every cycle against a counting model of the stream.
module tb_lp_decimator;

  logic        clk;
  logic        rst_n;
  logic [31:0] xd [2];
  logic        xv [2];
  logic        xr [2];
  logic [31:0] yd [2];
  logic        yv [2];
  logic        yr [2];
  logic        ps [2];
  logic [15:0] kc [2];

  int n_checks = 0;
  int n_fail   = 0;

  lp_decimator #(.W(32), .D(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .x_data(xd[0]), .x_valid(xv[0]), .x_ready(xr[0]),
    .y_data(yd[0]), .y_valid(yv[0]), .y_ready(yr[0]),
    .phase_sync(ps[0]), .keep_count(kc[0])
  );

  lp_decimator #(.W(32), .D(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .x_data(xd[1]), .x_valid(xv[1]), .x_ready(xr[1]),
    .y_data(yd[1]), .y_valid(yv[1]), .y_ready(yr[1]),
    .phase_sync(ps[1]), .keep_count(kc[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int dv(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: a sample is kept when the number of samples accepted since the
  // last reset/sync is a multiple of D; at most one kept sample awaits delivery.
  int          nacc  [2] = '{0, 0};
  int          pend  [2] = '{0, 0};
  int          m_cnt [2] = '{0, 0};
  logic [31:0] m_last[2] = '{32'd0, 32'd0};
  bit          on_keep[2];
  bit          exp_rdy[2];
  bit          m_hin  [2];
  bit          m_hout [2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      on_keep[i] = (nacc[i] % dv(i)) == 0;
      exp_rdy[i] = !on_keep[i] || (pend[i] == 0) || (yr[i] == 1'b1);
      m_hin[i]   = (xv[i] == 1'b1) && exp_rdy[i];
      m_hout[i]  = (pend[i] != 0) && (yr[i] == 1'b1);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        nacc[i]   <= 0;
        pend[i]   <= 0;
        m_cnt[i]  <= 0;
        m_last[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        pend[i]   <= pend[i] + ((m_hin[i] && on_keep[i]) ? 1 : 0) - (m_hout[i] ? 1 : 0);
        m_last[i] <= (m_hin[i] && on_keep[i]) ? xd[i] : m_last[i];
        m_cnt[i]  <= m_cnt[i] + (m_hout[i] ? 1 : 0);
        nacc[i]   <= (ps[i] == 1'b1) ? 0 : nacc[i] + (m_hin[i] ? 1 : 0);
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk(i == 0 ? "x_ready_d4" : "x_ready_d1", 64'(xr[i]), 64'(exp_rdy[i]));
      chk(i == 0 ? "y_valid_d4" : "y_valid_d1", 64'(yv[i]), 64'(pend[i] != 0));
      chk(i == 0 ? "y_data_d4" : "y_data_d1", 64'(yd[i]), 64'(m_last[i]));
      chk(i == 0 ? "keep_count_d4" : "keep_count_d1", 64'(kc[i]), 64'(m_cnt[i][15:0]));
    end
  end

  // Observed output handshakes, used by the directed literal checks.
  logic [31:0] olog0[$];
  logic [31:0] olog1[$];

  always @(posedge clk) begin
    if (rst_n) begin
      if (yv[0] && yr[0]) olog0.push_back(yd[0]);
      if (yv[1] && yr[1]) olog1.push_back(yd[1]);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_log0(input string nm, input int e[4], input int n);
    chk({nm, "_count"}, 64'(olog0.size()), 64'(n));
    for (int k = 0; k < n; k++) begin
      if (k < olog0.size()) chk(nm, 64'(olog0[k]), 64'(e[k]));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      xv[i] = 1'b0; xd[i] = '0; yr[i] = 1'b0; ps[i] = 1'b0;
    end
    step(2);
    rst_n = 1'b1;
    olog0.delete();
    olog1.delete();
    step(1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n_sent;
    int          cyc;
    logic        acc;
    logic [31:0] sq[$];

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      xv[i] = 1'b0; xd[i] = '0; yr[i] = 1'b0; ps[i] = 1'b0;
    end
    step(1);
    chk("reset_y_valid", 64'(yv[0]), 64'd0);
    chk("reset_y_data", 64'(yd[0]), 64'd0);
    chk("reset_keep_count", 64'(kc[0]), 64'd0);
    chk("reset_x_ready", 64'(xr[0]), 64'd1);

    // Continuous decimation
    do_reset();
    yr[0] = 1'b1;
    for (int v = 1; v <= 12; v++) begin
      xv[0] = 1'b1; xd[0] = 32'(v);
      step(1);
      if (v == 1) begin
        chk("cont_latency_valid", 64'(yv[0]), 64'd1);
        chk("cont_latency_data", 64'(yd[0]), 64'd1);
      end
    end
    xv[0] = 1'b0;
    step(2);
    chk_log0("cont_out", '{1, 5, 9, 0}, 3);
    chk("cont_keep_count", 64'(kc[0]), 64'd3);
    chk("cont_model_count", 64'(m_cnt[0]), 64'd3);

    // Backpressure
    do_reset();
    yr[0] = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      xv[0] = 1'b1; xd[0] = 32'(v);
      step(1);
    end
    xd[0] = 32'd5;
    @(negedge clk);
    chk("bp_x_ready_low", 64'(xr[0]), 64'd0);
    chk("bp_hold_data", 64'(yd[0]), 64'd1);
    step(2);
    chk("bp_still_held", 64'(yd[0]), 64'd1);
    yr[0] = 1'b1;
    step(1);
    chk("bp_release_data", 64'(yd[0]), 64'd5);
    chk("bp_release_valid", 64'(yv[0]), 64'd1);
    for (int v = 6; v <= 9; v++) begin
      xd[0] = 32'(v);
      step(1);
    end
    xv[0] = 1'b0;
    step(2);
    chk_log0("bp_out", '{1, 5, 9, 0}, 3);
    chk("bp_keep_count", 64'(kc[0]), 64'd3);

    // Phase sync coincident with the handshake of input 2
    do_reset();
    yr[0] = 1'b1;
    for (int v = 1; v <= 10; v++) begin
      xv[0] = 1'b1; xd[0] = 32'(v); ps[0] = (v == 2);
      step(1);
    end
    xv[0] = 1'b0; ps[0] = 1'b0;
    step(2);
    chk_log0("sync_out", '{1, 3, 7, 0}, 3);

    // Passthrough, D=1, random data and random y_ready
    do_reset();
    n_sent = 0;
    cyc = 0;
    xv[1] = 1'b1;
    xd[1] = $urandom;
    while (n_sent < 40 && cyc < 2000) begin
      yr[1] = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = xr[1];
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        sq.push_back(xd[1]);
        n_sent++;
        xd[1] = $urandom;
      end
    end
    xv[1] = 1'b0;
    yr[1] = 1'b1;
    step(3);
    chk("pt_sent", 64'(n_sent), 64'd40);
    chk("pt_out_count", 64'(olog1.size()), 64'(sq.size()));
    for (int k = 0; k < sq.size(); k++) begin
      if (k < olog1.size()) chk("pt_out", 64'(olog1[k]), 64'(sq[k]));
    end

    // Reset mid-stream while sample 5 is held
    do_reset();
    yr[0] = 1'b1;
    for (int v = 1; v <= 5; v++) begin
      xv[0] = 1'b1; xd[0] = 32'(v);
      step(1);
    end
    xv[0] = 1'b0;
    yr[0] = 1'b0;
    @(negedge clk);
    chk("mid_held_data", 64'(yd[0]), 64'd5);
    chk("mid_pre_count", 64'(kc[0]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_async_valid", 64'(yv[0]), 64'd0);
    chk("mid_async_data", 64'(yd[0]), 64'd0);
    chk("mid_async_count", 64'(kc[0]), 64'd0);
    chk("mid_async_ready", 64'(xr[0]), 64'd1);
    step(1);
    rst_n = 1'b1;
    olog0.delete();
    yr[0] = 1'b1; xv[0] = 1'b1; xd[0] = 32'h77;
    step(1);
    xv[0] = 1'b0;
    step(2);
    chk_log0("mid_after_reset", '{32'h77, 0, 0, 0}, 1);

    // Counter wrap on the D=1 instance
    do_reset();
    yr[1] = 1'b1;
    xv[1] = 1'b1;
    for (int k = 0; k < 65535; k++) begin
      xd[1] = 32'(k);
      step(1);
    end
    xv[1] = 1'b0;
    step(3);
    chk("wrap_at_max", 64'(kc[1]), 64'hffff);
    xv[1] = 1'b1;
    xd[1] = 32'h1234;
    step(1);
    xv[1] = 1'b0;
    step(3);
    chk("wrap_to_zero", 64'(kc[1]), 64'd0);
    chk("wrap_model_count", 64'(m_cnt[1]), 64'd65536);
    olog1.delete();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lp_decimator.md
# lp_decimator

Rate-reduction stage that sits directly downstream of the low-pass FIR in the FFT front end. It consumes the filtered sample stream over a `dstream` handshake and forwards every D-th sample to the FFT input. The other D-1 samples are accepted and discarded. It provides correct ready/valid backpressure, a phase-resynchronisation input and a count of emitted samples for debug.

## Interface
- `W`, default 32: sample width. Data passes through bit-exact; Q-format is unchanged.
- `D`, default 4: decimation factor, legal range 1..256. Phase counter width is `max(1, $clog2(D))`.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: one clock; reset is asynchronous and active-low.
- `x`  dstream.in  W: filtered input stream (`data`, `valid`, `ready`).
- `y`  dstream.out  W: decimated output stream (`data`, `valid`, `ready`).
- `phase_sync`  in  1: synchronous request to force the decimation phase to 0.
- `keep_count`  out  16: number of output handshakes completed; wraps.

## Operation
- State:
  - phase counter `ph`
  - output register `y.data` and `y.valid`
  - `keep_count`
- Input handshake `hs_in = x.valid & x.ready`. Output handshake `hs_out = y.valid & y.ready`.
- Keep rule: a sample accepted while `ph == 0` is kept. Samples accepted with `ph != 0` are dropped and produce no output.
- `x.ready = (ph != 0) | ~y.valid | y.ready`. This is combinational.
  - Drop-phase samples are never stalled.
  - A keep-phase sample stalls only while the output register holds an unconsumed sample and `y.ready` is low.
- Phase update:
  - On `hs_in`: `ph <= (ph == D-1) ? 0 : ph + 1`.
  - `phase_sync` high at an edge forces `ph <= 0` and overrides any increment.
  - If `phase_sync` coincides with `hs_in`, the sample is first classified using the current `ph`; the next sample then lands on phase 0.
- Output register:
  - Kept `hs_in`: `y.data <= x.data`, `y.valid <= 1`. This holds regardless of a simultaneous `hs_out`, so back-to-back operation has no bubble.
  - `hs_out` with no kept `hs_in`: `y.valid <= 0`. `y.data` holds its value.
  - Otherwise `y.data` and `y.valid` hold. `y.data` must not change while `y.valid & ~y.ready`.
- `keep_count` increments by 1 on each `hs_out` and wraps from 65535 to 0.
- `D = 1`: `ph` stays 0 and every sample is kept, so the block acts as a one-deep registered pipeline stage.

## Timing
- Reset values (asynchronous, applied immediately on `rst_n` low):
  - `y.valid = 0`, `y.data = 0`
  - `ph = 0`, `keep_count = 0`
  - `x.ready` follows its equation, so it is 1 during reset.
- Reset asserted mid-operation discards any pending output sample and the current phase. The first sample after reset release is kept.
- Latency: a kept sample is on `y.data` with `y.valid = 1` in the cycle after its input handshake.
- Throughput:
  - With `y.ready` held high: one output per D input handshakes, and up to one input per cycle.
  - With `y.ready` low: drop-phase inputs continue to be accepted. The keep-phase input waits.
- Valid is never withdrawn without a handshake except by reset.
- No combinational path from `x.valid` or `x.data` to any `y` signal. The only combinational path through the block is `y.ready` to `x.ready`.

## Test plan
- **Continuous decimation:** D=4, `y.ready=1`, inputs 1..12 on consecutive cycles.
  - Outputs 1, 5, 9, each valid exactly one cycle after its input.
  - `keep_count = 3`.
- **Backpressure:** D=4, `y.ready=0`, inputs 1..6.
  - Sample 1 is held on `y`. Samples 2, 3, 4 are accepted.
  - `x.ready` drops to 0 with sample 5 presented and `y.data` stays 1.
  - Raising `y.ready` releases 1, then 5 on the next cycle, then the stream resumes.
- **Phase sync:** D=4, inputs 1..10, `phase_sync` pulsed in the same cycle as the handshake of input 2.
  - Outputs 1, 3, 7. Input 2 is dropped.
- **Passthrough:** D=1, random data with random `y.ready`.
  - Output sequence equals input sequence with no loss, duplication, or change while stalled.
- **Reset mid-stream:** D=4, drive `rst_n` low while `y.valid=1` holds sample 5.
  - `y.valid`, `y.data`, `ph` and `keep_count` go to 0 immediately, without waiting for a clock edge.
  - The first input after release is output.
- **Counter wrap:** preload with 65535 output handshakes and perform one more.
  - `keep_count` reads 0.
